sip_round_engine: RTL

- Iterative, parametrised SipRound core for the SipHash datapath.
- Accepts a four-word state plus a round count over a valid/ready handshake.
- Applies one full SipRound per clock, in place, for the requested number of rounds, then presents the result on a valid/ready output.
- Word width and rotation constants are parameters, so the same block serves SipHash-c-d (64-bit) and HalfSipHash (32-bit). It replaces fixed per-stage pipelines in compression and finalisation.

---
 rtl/sip_round_engine.sv | 107 ++++++++++
 1 files changed

// File: rtl/sip_round_engine.sv
// Iterative SipRound engine: loads a four-word state, applies one full SipRound per clock
// for a requested count, then holds the result until the consumer takes it.
module sip_round_engine #(
  parameter int unsigned WORD_W   = 64,
  parameter int unsigned ROT_A    = 13,
  parameter int unsigned ROT_B    = 16,
  parameter int unsigned ROT_C    = 17,
  parameter int unsigned ROT_D    = 21,
  parameter int unsigned ROT_E    = 32,
  parameter int unsigned ROUNDS_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clear,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [ROUNDS_W-1:0] in_rounds,
  input  logic [WORD_W-1:0]   v0_in,
  input  logic [WORD_W-1:0]   v1_in,
  input  logic [WORD_W-1:0]   v2_in,
  input  logic [WORD_W-1:0]   v3_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WORD_W-1:0]   v0_out,
  output logic [WORD_W-1:0]   v1_out,
  output logic [WORD_W-1:0]   v2_out,
  output logic [WORD_W-1:0]   v3_out,
  output logic                busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t              state, state_nxt;
  logic [ROUNDS_W-1:0] cnt;
  logic                load, step;
  logic [WORD_W-1:0]   h0_sum, h0, h1, h2, h3;
  logic [WORD_W-1:0]   s2_sum, r0, r1, r2, r3;

  function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] x, input int unsigned r);
    return (x << r) | (x >> (WORD_W - r));
  endfunction

  // One full SipRound (both halves) on the current register contents
  always_comb begin
    h0_sum = v0_out + v1_out;
    h1     = rotl(v1_out, ROT_A) ^ h0_sum;
    h0     = rotl(h0_sum, ROT_E);
    h2     = v2_out + v3_out;
    h3     = rotl(v3_out, ROT_B) ^ h2;
    s2_sum = h2 + h1;
    r1     = rotl(h1, ROT_C) ^ s2_sum;
    r2     = rotl(s2_sum, ROT_E);
    r0     = h0 + h3;
    r3     = rotl(h3, ROT_D) ^ r0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (in_valid) state_nxt = (in_rounds == '0) ? DONE : RUN;
      RUN:     if (cnt == ROUNDS_W'(1)) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    // Abort wins over every other transition
    if (clear) state_nxt = IDLE;
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    busy      = (state != IDLE);
    load      = (state == IDLE) && in_valid && !clear;
    step      = (state == RUN) && !clear;
  end

  // State words and round counter; clear zeroes the counter but keeps the words
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_out <= '0;
      v1_out <= '0;
      v2_out <= '0;
      v3_out <= '0;
      cnt    <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (load) begin
      v0_out <= v0_in;
      v1_out <= v1_in;
      v2_out <= v2_in;
      v3_out <= v3_in;
      cnt    <= in_rounds;
    end else if (step) begin
      v0_out <= r0;
      v1_out <= r1;
      v2_out <= r2;
      v3_out <= r3;
      cnt    <= cnt - ROUNDS_W'(1);
    end
  end

endmodule
